// File: rtl/data_memory_pkg.sv
// Shared encodings and access helpers for the data_memory block.
package data_memory_pkg;

    // Access size as carried on req_size
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Request/response sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // True when the byte offset is not a multiple of the access size
    function automatic logic is_misaligned(size_e size, logic [2:0] offset);
        logic result;
        case (size)
            SZ_H:    result = offset[0];
            SZ_W:    result = |offset[1:0];
            SZ_D:    result = |offset;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // Byte lanes touched by an access of the given size at the given offset
    function automatic logic [7:0] byte_enables(size_e size, logic [2:0] offset);
        logic [7:0] lanes;
        case (size)
            SZ_B:    lanes = 8'h01 << offset;
            SZ_H:    lanes = 8'h03 << offset;
            SZ_W:    lanes = 8'h0F << offset;
            default: lanes = 8'hFF;
        endcase
        return lanes;
    endfunction

    // Align the addressed bytes to bit 0, then sign- or zero-extend to 64 bits
    function automatic logic [63:0] extend_load(logic [63:0] word, size_e size,
                                                logic [2:0] offset, logic is_unsigned);
        logic [63:0] shifted;
        logic [63:0] result;
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_B: result = is_unsigned ? {56'd0, shifted[7:0]}
                                       : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H: result = is_unsigned ? {48'd0, shifted[15:0]}
                                       : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: result = is_unsigned ? {32'd0, shifted[31:0]}
                                       : {{32{shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/data_memory_mem_array_be.sv
// Word-organised storage with per-byte write enables and combinational read.
// Contents start at zero and are never touched by reset.
module mem_array_be #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [7:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [63:0]                    wdata,
    output logic [63:0]                    rdata
);

    logic [63:0] mem [DEPTH_WORDS] = '{default: '0};

    // Byte-masked write of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory.sv
// Single-port data memory with valid/ready request and response channels,
// byte/half/word/double accesses, alignment and range faults, and a
// configurable request-to-response latency.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault
);

    localparam int unsigned     AW     = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] LIMIT  = XLEN'(DEPTH_WORDS) << 3;
    localparam logic [3:0]      LAT_M1 = 4'(LATENCY - 1);

    state_e      state;
    logic [3:0]  cnt;

    size_e       size;
    logic [2:0]  offset;
    logic [AW-1:0] index;
    logic        fault;
    logic        accept;
    logic        mem_we;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [63:0] load_value;

    assign size       = size_e'(req_size);
    assign offset     = req_addr[2:0];
    assign index      = req_addr[AW+2:3];
    assign fault      = is_misaligned(size, offset) || (req_addr >= LIMIT);
    assign accept     = req_valid && req_ready;
    assign mem_we     = accept && req_we && !fault;
    assign mem_be     = byte_enables(size, offset);
    assign mem_wdata  = req_wdata << {offset, 3'b000};
    assign load_value = extend_load(mem_rdata, size, offset, req_unsigned);

    mem_array_be #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (index),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Sequencing FSM; response fields are captured at acceptance and held
    // until the consumer takes them. req_ready is registered so it stays low
    // for the first edge after reset and during the handshake cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        rsp_fault <= fault;
                        rsp_rdata <= (fault || req_we) ? '0 : load_value;
                        if (LATENCY <= 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt >= LAT_M1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data and address width (only 64 is supported).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 64-bit words (power of two, >=2).
REQ-003 SHALL have parameter LATENCY, default 1, meaning cycles from request acceptance to rsp_valid (range 1..15).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  block can accept a request.
REQ-008 SHALL have port req_we  in  1  1=store, 0=load.
REQ-009 SHALL have port req_size  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
REQ-010 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_addr  in  XLEN  byte address.
REQ-012 SHALL have port req_wdata  in  XLEN  store data, right-aligned (low bytes used).
REQ-013 SHALL have port rsp_valid  out  1  response present.
REQ-014 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-015 SHALL have port rsp_rdata  out  XLEN  load result, extended to XLEN; 0 for stores and faults.
REQ-016 SHALL have port rsp_fault  out  1  request was misaligned or out of range.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-018 SHALL implement states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL transition IDLE->WAIT on acceptance when LATENCY>1, IDLE->RESP when LATENCY=1; WAIT->RESP after LATENCY-1 cycles counted by an internal counter.
REQ-020 SHALL assert rsp_valid only in RESP, holding rsp_rdata/rsp_fault stable until rsp_valid && rsp_ready, then return to IDLE (no back-to-back acceptance in that same cycle).
REQ-021 SHALL decode word index = req_addr[log2(DEPTH_WORDS)+2:3] and byte offset = req_addr[2:0].
REQ-022 SHALL flag misaligned when size=1 && addr[0]!=0, size=2 && addr[1:0]!=0, size=3 && addr[2:0]!=0.
REQ-023 SHALL flag out-of-range when req_addr >= DEPTH_WORDS*8.
REQ-024 SHALL, on a faulting request, perform no memory write, return rsp_fault=1 and rsp_rdata=0.
REQ-025 SHALL commit stores at the acceptance edge, writing only the 1/2/4/8 bytes selected by size and offset, other bytes unchanged.
REQ-026 SHALL capture load data at the acceptance edge, shift right by offset*8, mask to size, then sign- or zero-extend per req_unsigned.
REQ-027 SHALL ignore req_valid and all request fields outside IDLE.
REQ-028 SHALL initialise all memory words to 0 at time zero; memory contents SHALL NOT be altered by reset.

Reset
REQ-029 SHALL, while rst_n=0, force state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_fault=0, rsp_rdata=0.
REQ-030 SHALL drive req_ready=1 from the first edge after rst_n deasserts.
REQ-031 SHALL, on reset during WAIT or RESP, discard the pending response; a store already committed at acceptance remains in memory.

Structure
REQ-032 SHALL place size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the state encoding in shared package data_memory_pkg.
REQ-033 SHALL implement storage as one sub-module mem_array_be: DEPTH_WORDS x 64-bit array with 8-bit byte-write-enable and combinational read.

Verification
REQ-034 Store double 0x0123456789ABCDEF @0x10, load double @0x10 -> rdata 0x0123456789ABCDEF, fault 0.
REQ-035 Store byte 0x80 @0x13, load signed byte @0x13 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80; load double @0x10 -> 0x0123456780ABCDEF.
REQ-036 Load half @0x11 -> fault 1, rdata 0; store word @0x2002 (DEPTH_WORDS=1024) -> fault 1, memory unchanged.
REQ-037 LATENCY=4, rsp_ready held 0 for 3 cycles: rsp_valid rises 4 cycles after acceptance, data stable, req_ready=0 until handshake.
REQ-038 Assert rst_n=0 in WAIT after store 0xAA @0x8: rsp_valid=0 immediately; subsequent load byte @0x8 -> 0xAA.
